alu_port_arbiter: RTL and testbench
===================================

// Module: alu_port_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer that shares one ALU datapath (operand muxes + ALU) among
//   NUM_REQ requesters. It picks a requester, steers that requester's operands and control
//   through the ALU input muxes (alu_sel), starts the op, waits a fixed ALU latency, then
//   returns the result with a per-requester done pulse. It sits between the issue ports and the
//   shared ALU.
// PARAMETERS
//   NUM_REQ  4   number of requesters (2..8)
//   WIDTH    32  operand/result width
//   CTRL_W   4   ALU control (opcode) width
//   ALU_LAT  1   cycles from the alu_start cycle until alu_z is valid (>=1)
// PORTS
//   clk       in   1               rising-edge clock
//   rst_n     in   1               asynchronous, active-low reset
//   req       in   NUM_REQ         request per port; held high until that port's gnt
//   a_in      in   NUM_REQ*WIDTH   operand A, port i at [i*WIDTH +: WIDTH]
//   b_in      in   NUM_REQ*WIDTH   operand B, same packing
//   ctrl_in   in   NUM_REQ*CTRL_W  ALU control, port i at [i*CTRL_W +: CTRL_W]
//   gnt       out  NUM_REQ         one-hot 1-cycle pulse: request accepted, operands latched
//   alu_sel   out  clog2(NUM_REQ)  index of current owner (drives operand mux selects)
//   alu_a     out  WIDTH           latched operand A to ALU
//   alu_b     out  WIDTH           latched operand B to ALU
//   alu_ctrl  out  CTRL_W          latched control to ALU
//   alu_start out  1               1-cycle pulse: ALU inputs valid, op begins
//   alu_z     in   WIDTH           ALU result
//   done      out  NUM_REQ         one-hot 1-cycle pulse: z_out valid for that port
//   z_out     out  WIDTH           captured result; held until next done
//   busy      out  1               high in ISSUE/WAIT
// BEHAVIOUR
//   - All outputs registered. Reset (async, rst_n=0): state=IDLE, gnt=0, done=0, alu_start=0,
//     busy=0, alu_sel=0, alu_a=alu_b=0, alu_ctrl=0, z_out=0, pointer last=NUM_REQ-1
//     (port 0 has highest priority first).
//   - FSM IDLE -> ISSUE -> WAIT -> IDLE:
//     IDLE : if |req at the edge: winner = first set req scanning last+1, last+2, ... (mod
//            NUM_REQ). Latch winner's a/b/ctrl into alu_a/b/ctrl, alu_sel=winner, gnt[winner]=1.
//            Go to ISSUE. No req: stay in IDLE, no outputs change.
//     ISSUE: alu_start=1 for exactly this cycle; wait counter loaded with ALU_LAT; go to WAIT.
//     WAIT : ALU_LAT cycles. On the edge ending the last WAIT cycle: z_out<=alu_z,
//            done[owner]=1, last<=owner; go to IDLE.
//   - Timing (req sampled at edge E0): gnt and alu_start high in cycle 1. done and z_out
//     valid in cycle ALU_LAT+2. Next gnt at the earliest in cycle ALU_LAT+3.
//     One op per ALU_LAT+2 cycles.
//   - IDLE arbitrates in the same cycle that done is high (back-to-back service).
//   - req is ignored outside IDLE. A req dropped before being granted is lost; no state kept.
//   - A requester still asserting req after its gnt is a new request. Round-robin places it
//     last, so with all ports requesting the grant order is 0,1,..,NUM_REQ-1,0,...
//   - alu_a/b/ctrl/alu_sel hold their values from gnt until the next gnt. a_in/b_in may
//     change after gnt without effect.
//   - Reset mid-operation (ISSUE/WAIT) aborts the op: no done, all outputs go to reset
//     values at once.
//   - No arithmetic in the block. The counter is clog2(ALU_LAT+1) bits and never wraps.
// TESTING
//   1 reset: rst_n=0 with clk running -> gnt=done=0, alu_start=0, z_out=0, busy=0,
//     alu_sel=0 immediately, without waiting for an edge.
//   2 single op, ALU_LAT=1: req=4'b0100, a=5, b=3, ctrl=2; ALU model adds ->
//     gnt=0100 cycle1, alu_sel=2, alu_start cycle1, done=0100 cycle3, z_out=8.
//   3 fairness: req=4'b1111 held, each port's a=i -> gnt order 0,1,2,3,0,1; gnt every 3 cycles.
//   4 drop: req[1] pulsed only while busy -> never granted, no done[1]; req[3] queued -> served.
//   5 abort: rst_n low during WAIT with ALU_LAT=3 -> no done pulse. After release, a new
//     req[0] is granted first.
//   6 latency: ALU_LAT=3, req[2] at E0 -> gnt cycle1, done cycle5; z_out = alu_z at the edge
//     ending cycle4.

Source files
------------

// File: rtl/alu_port_arbiter.sv
// ---------------------------------------------------------------------------
// alu_port_arbiter
//   Round-robin arbiter and sequencer sharing one ALU datapath among NUM_REQ
//   requesters. It picks a requester, latches its operands and control onto
//   the ALU inputs, pulses alu_start, waits ALU_LAT cycles, then captures the
//   ALU result and pulses that requester's done bit.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     req        per-port request, held until that port's gnt
//     a_in/b_in  per-port operands, port i at [i*WIDTH +: WIDTH]
//     ctrl_in    per-port ALU control, port i at [i*CTRL_W +: CTRL_W]
//     gnt        one-hot pulse: request accepted, operands latched
//     alu_sel    index of current owner (operand mux select)
//     alu_a/b    latched operands to the ALU
//     alu_ctrl   latched control to the ALU
//     alu_start  pulse: ALU inputs valid, op begins
//     alu_z      ALU result
//     done       one-hot pulse: z_out valid for that port
//     z_out      captured result, held until the next done
//     busy       high while an op is in flight (ISSUE/WAIT)
// ---------------------------------------------------------------------------
module alu_port_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int CTRL_W  = 4,
   parameter int ALU_LAT = 1,
   localparam int SEL_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CNT_W  = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*WIDTH-1:0]   a_in,
   input  logic [NUM_REQ*WIDTH-1:0]   b_in,
   input  logic [NUM_REQ*CTRL_W-1:0]  ctrl_in,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [SEL_W-1:0]           alu_sel,
   output logic [WIDTH-1:0]           alu_a,
   output logic [WIDTH-1:0]           alu_b,
   output logic [CTRL_W-1:0]          alu_ctrl,
   output logic                       alu_start,
   input  logic [WIDTH-1:0]           alu_z,
   output logic [NUM_REQ-1:0]         done,
   output logic [WIDTH-1:0]           z_out,
   output logic                       busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   localparam logic [CNT_W-1:0]   LAT_LOAD = CNT_W'(ALU_LAT);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [SEL_W-1:0]   LAST_RST = SEL_W'(NUM_REQ - 1);
   localparam logic [SEL_W:0]     NUM_EXT  = (SEL_W + 1)'(NUM_REQ);
   localparam logic [NUM_REQ-1:0] OH_ZERO  = {{(NUM_REQ - 1){1'b0}}, 1'b1};

   logic [1:0]          state_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [SEL_W-1:0]    last_r;
   logic [SEL_W-1:0]    sel_r;
   logic [WIDTH-1:0]    a_r;
   logic [WIDTH-1:0]    b_r;
   logic [CTRL_W-1:0]   ctrl_r;
   logic [WIDTH-1:0]    z_r;
   logic [NUM_REQ-1:0]  gnt_r;
   logic [NUM_REQ-1:0]  done_r;
   logic                start_r;
   logic                busy_r;

   logic                win_vld_s;
   logic [SEL_W-1:0]    win_idx_s;
   logic [SEL_W:0]      scan_s;
   logic                take_s;
   logic                finish_s;

   // Round-robin scan: first asserted request starting just after the last owner.
   always_comb begin
      win_vld_s = 1'b0;
      win_idx_s = '0;
      scan_s    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_s = {1'b0, last_r} + (SEL_W + 1)'(k);
         if (scan_s >= NUM_EXT) begin
            scan_s = scan_s - NUM_EXT;
         end else begin
            scan_s = scan_s;
         end
         if (!win_vld_s && req[scan_s[SEL_W-1:0]]) begin
            win_vld_s = 1'b1;
            win_idx_s = scan_s[SEL_W-1:0];
         end else begin
            win_vld_s = win_vld_s;
         end
      end
   end

   // Accept a winner only from IDLE; finish on the last WAIT cycle.
   always_comb begin
      take_s   = (state_r == ST_IDLE) && win_vld_s;
      finish_s = (state_r == ST_WAIT) && (cnt_r == CNT_ONE);
   end

   // Sequencer state, latency counter, round-robin pointer and pulse outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         last_r  <= LAST_RST;
         gnt_r   <= '0;
         done_r  <= '0;
         start_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         gnt_r   <= '0;
         done_r  <= '0;
         start_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (take_s) begin
                  gnt_r   <= OH_ZERO << win_idx_s;
                  start_r <= 1'b1;
                  busy_r  <= 1'b1;
                  state_r <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt_r   <= LAT_LOAD;
               state_r <= ST_WAIT;
            end
            ST_WAIT: begin
               if (finish_s) begin
                  done_r  <= OH_ZERO << sel_r;
                  last_r  <= sel_r;
                  busy_r  <= 1'b0;
                  cnt_r   <= '0;
                  state_r <= ST_IDLE;
               end else begin
                  cnt_r   <= cnt_r - CNT_ONE;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               cnt_r   <= '0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Operand/control latch at grant; result capture at the end of WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_r  <= '0;
         a_r    <= '0;
         b_r    <= '0;
         ctrl_r <= '0;
         z_r    <= '0;
      end else begin
         if (take_s) begin
            sel_r  <= win_idx_s;
            a_r    <= a_in[win_idx_s*WIDTH +: WIDTH];
            b_r    <= b_in[win_idx_s*WIDTH +: WIDTH];
            ctrl_r <= ctrl_in[win_idx_s*CTRL_W +: CTRL_W];
         end
         if (finish_s) begin
            z_r <= alu_z;
         end
      end
   end

   assign gnt       = gnt_r;
   assign done      = done_r;
   assign alu_start = start_r;
   assign busy      = busy_r;
   assign alu_sel   = sel_r;
   assign alu_a     = a_r;
   assign alu_b     = b_r;
   assign alu_ctrl  = ctrl_r;
   assign z_out     = z_r;

endmodule

// File: tb/tb_alu_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_port_arbiter
//   Two instances share the clock and reset: u_l1 (ALU_LAT=1) and u_l3
//   (ALU_LAT=3). A fake ALU returns a+b+zmix so result capture timing is
//   visible. A transaction-level model (grant time, capture time, owner)
//   predicts every output each cycle; directed scenarios precede random ones.
// ---------------------------------------------------------------------------
module tb_alu_port_arbiter;
   localparam int N = 4;
   localparam int W = 32;
   localparam int C = 4;

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     req_v   [2];
   logic [N*W-1:0]   a_v     [2];
   logic [N*W-1:0]   b_v     [2];
   logic [N*C-1:0]   c_v     [2];
   logic [N-1:0]     o_gnt   [2];
   logic [N-1:0]     o_done  [2];
   logic [1:0]       o_sel   [2];
   logic [W-1:0]     o_a     [2];
   logic [W-1:0]     o_b     [2];
   logic [W-1:0]     o_z     [2];
   logic [W-1:0]     z_in    [2];
   logic [C-1:0]     o_ctrl  [2];
   logic             o_start [2];
   logic             o_busy  [2];
   logic [W-1:0]     zmix;

   // model state
   int               lat [2];
   int               m_last [2];
   int               m_owner [2];
   int               m_cap [2];
   bit               m_active [2];
   logic [N-1:0]     e_gnt [2];
   logic [N-1:0]     e_done [2];
   logic [1:0]       e_sel [2];
   logic [W-1:0]     e_a [2];
   logic [W-1:0]     e_b [2];
   logic [W-1:0]     e_z [2];
   logic [C-1:0]     e_ctrl [2];
   logic             e_start [2];
   logic             e_busy [2];
   int               n_edge;
   int               n_tests;
   int               n_fail;

   assign z_in[0] = o_a[0] + o_b[0] + zmix;
   assign z_in[1] = o_a[1] + o_b[1] + zmix;

   alu_port_arbiter #(.NUM_REQ(N), .WIDTH(W), .CTRL_W(C), .ALU_LAT(1)) u_l1 (
      .clk(clk), .rst_n(rst_n), .req(req_v[0]), .a_in(a_v[0]), .b_in(b_v[0]),
      .ctrl_in(c_v[0]), .gnt(o_gnt[0]), .alu_sel(o_sel[0]), .alu_a(o_a[0]),
      .alu_b(o_b[0]), .alu_ctrl(o_ctrl[0]), .alu_start(o_start[0]),
      .alu_z(z_in[0]), .done(o_done[0]), .z_out(o_z[0]), .busy(o_busy[0]));

   alu_port_arbiter #(.NUM_REQ(N), .WIDTH(W), .CTRL_W(C), .ALU_LAT(3)) u_l3 (
      .clk(clk), .rst_n(rst_n), .req(req_v[1]), .a_in(a_v[1]), .b_in(b_v[1]),
      .ctrl_in(c_v[1]), .gnt(o_gnt[1]), .alu_sel(o_sel[1]), .alu_a(o_a[1]),
      .alu_b(o_b[1]), .alu_ctrl(o_ctrl[1]), .alu_start(o_start[1]),
      .alu_z(z_in[1]), .done(o_done[1]), .z_out(o_z[1]), .busy(o_busy[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset(input int d);
      m_active[d] = 1'b0;
      m_last[d]   = N - 1;
      m_owner[d]  = 0;
      m_cap[d]    = 0;
      e_gnt[d]    = '0;
      e_done[d]   = '0;
      e_sel[d]    = '0;
      e_a[d]      = '0;
      e_b[d]      = '0;
      e_z[d]      = '0;
      e_ctrl[d]   = '0;
      e_start[d]  = 1'b0;
      e_busy[d]   = 1'b0;
   endtask

   // One clock edge of the transaction model.
   task automatic model_step(input int d);
      int win;
      bit found;
      logic [N-1:0] oh;
      e_gnt[d]   = '0;
      e_done[d]  = '0;
      e_start[d] = 1'b0;
      if (!m_active[d]) begin
         if (req_v[d] != '0) begin
            found = 1'b0;
            win   = 0;
            for (int k = 1; k <= N; k++) begin
               int p;
               p = (m_last[d] + k) % N;
               if (!found && req_v[d][p]) begin
                  found = 1'b1;
                  win   = p;
               end
            end
            oh = '0;
            oh[win] = 1'b1;
            m_owner[d]  = win;
            e_sel[d]    = 2'(win);
            e_a[d]      = a_v[d][win*W +: W];
            e_b[d]      = b_v[d][win*W +: W];
            e_ctrl[d]   = c_v[d][win*C +: C];
            e_gnt[d]    = oh;
            e_start[d]  = 1'b1;
            m_active[d] = 1'b1;
            m_cap[d]    = n_edge + 1 + lat[d];
         end
      end else if (n_edge == m_cap[d]) begin
         oh = '0;
         oh[m_owner[d]] = 1'b1;
         e_z[d]      = e_a[d] + e_b[d] + zmix;
         e_done[d]   = oh;
         m_last[d]   = m_owner[d];
         m_active[d] = 1'b0;
      end
      e_busy[d] = m_active[d];
   endtask

   task automatic check_dut(input int d);
      chk_val($sformatf("u%0d.gnt", d),   64'(o_gnt[d]),   64'(e_gnt[d]));
      chk_val($sformatf("u%0d.done", d),  64'(o_done[d]),  64'(e_done[d]));
      chk_val($sformatf("u%0d.start", d), 64'(o_start[d]), 64'(e_start[d]));
      chk_val($sformatf("u%0d.busy", d),  64'(o_busy[d]),  64'(e_busy[d]));
      chk_val($sformatf("u%0d.sel", d),   64'(o_sel[d]),   64'(e_sel[d]));
      chk_val($sformatf("u%0d.a", d),     64'(o_a[d]),     64'(e_a[d]));
      chk_val($sformatf("u%0d.b", d),     64'(o_b[d]),     64'(e_b[d]));
      chk_val($sformatf("u%0d.ctrl", d),  64'(o_ctrl[d]),  64'(e_ctrl[d]));
      chk_val($sformatf("u%0d.z", d),     64'(o_z[d]),     64'(e_z[d]));
   endtask

   // Advance one clock: model at the rising edge, compare at the falling edge.
   task automatic cycle();
      @(posedge clk);
      n_edge++;
      for (int d = 0; d < 2; d++) begin
         if (rst_n) model_step(d);
         else       model_reset(d);
      end
      @(negedge clk);
      check_dut(0);
      check_dut(1);
   endtask

   // Asynchronous reset mid-cycle, checked before any clock edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset(0);
      model_reset(1);
      check_dut(0);
      check_dut(1);
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   task automatic set_port(input int d, input int p, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [C-1:0] c);
      a_v[d][p*W +: W] = a;
      b_v[d][p*W +: W] = b;
      c_v[d][p*C +: C] = c;
   endtask

   initial begin
      int exp_ord [6];
      int ord_q [$];
      int cyc_q [$];
      int seen1, seen3, gk, dk, first_gnt;

      n_tests = 0;
      n_fail  = 0;
      n_edge  = 0;
      zmix    = '0;
      lat[0]  = 1;
      lat[1]  = 3;
      rst_n   = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req_v[d] = '0;
         a_v[d]   = '0;
         b_v[d]   = '0;
         c_v[d]   = '0;
         model_reset(d);
      end
      exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 2;
      exp_ord[3] = 3; exp_ord[4] = 0; exp_ord[5] = 1;

      // 1: reset
      @(negedge clk);
      do_reset();
      cycle();

      // 2: single op on port 2, ALU_LAT=1
      set_port(0, 2, 32'd5, 32'd3, 4'd2);
      req_v[0] = 4'b0100;
      cycle();
      chk_val("t2_gnt_c1", 64'(o_gnt[0]), 64'h4);
      chk_val("t2_sel", 64'(o_sel[0]), 64'h2);
      req_v[0] = 4'b0000;
      cycle();
      cycle();
      chk_val("t2_done_c3", 64'(o_done[0]), 64'h4);
      chk_val("t2_z", 64'(o_z[0]), 64'd8);
      repeat (3) cycle();

      // 3: fairness with all ports requesting
      do_reset();
      for (int p = 0; p < N; p++) set_port(0, p, W'(p), W'(p), C'(p));
      req_v[0] = 4'b1111;
      for (int k = 1; k <= 18; k++) begin
         cycle();
         for (int p = 0; p < N; p++) begin
            if (o_gnt[0][p]) begin
               ord_q.push_back(p);
               cyc_q.push_back(k);
            end
         end
      end
      req_v[0] = 4'b0000;
      chk_val("t3_count", 64'(ord_q.size() >= 6), 64'd1);
      if (ord_q.size() >= 6) begin
         for (int i = 0; i < 6; i++) chk_val("t3_order", 64'(ord_q[i]), 64'(exp_ord[i]));
         for (int i = 1; i < 6; i++) chk_val("t3_spacing", 64'(cyc_q[i] - cyc_q[i-1]), 64'd3);
      end
      repeat (4) cycle();

      // 4: request dropped while busy is lost; held request is served
      do_reset();
      seen1 = 0;
      seen3 = 0;
      req_v[0] = 4'b0001;
      cycle();
      req_v[0] = 4'b1010;
      cycle();
      req_v[0] = 4'b1000;
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (o_gnt[0][1] || o_done[0][1]) seen1++;
         if (o_done[0][3]) seen3++;
         if (o_gnt[0][3]) req_v[0] = 4'b0000;
      end
      chk_val("t4_drop", 64'(seen1), 64'd0);
      chk_val("t4_queued", 64'(seen3), 64'd1);

      // 5: reset during WAIT aborts the op; port 0 wins first afterwards
      do_reset();
      seen1 = 0;
      set_port(1, 2, 32'd7, 32'd9, 4'd1);
      req_v[1] = 4'b0100;
      cycle();
      req_v[1] = 4'b0000;
      cycle();
      cycle();
      chk_val("t5_in_wait", 64'(o_busy[1]), 64'd1);
      do_reset();
      req_v[1] = 4'b1111;
      cycle();
      first_gnt = int'(o_gnt[1]);
      req_v[1] = 4'b0000;
      for (int k = 0; k < 8; k++) begin
         cycle();
         if (o_done[1][2]) seen1++;
      end
      chk_val("t5_first_gnt", 64'(first_gnt), 64'h1);
      chk_val("t5_no_done2", 64'(seen1), 64'd0);

      // 6: ALU_LAT=3 latency with a varying ALU result
      gk = -1;
      dk = -1;
      set_port(1, 2, 32'h100, 32'h23, 4'd5);
      req_v[1] = 4'b0100;
      for (int k = 1; k <= 20; k++) begin
         cycle();
         if (o_gnt[1] != '0 && gk < 0) begin
            gk = k;
            req_v[1] = 4'b0000;
         end
         if (o_done[1] != '0 && dk < 0) dk = k;
         zmix = $urandom;
      end
      chk_val("t6_gnt_cycle", 64'(gk), 64'd1);
      chk_val("t6_done_cycle", 64'(dk), 64'd5);

      // random traffic on both instances
      for (int k = 0; k < 3000; k++) begin
         for (int d = 0; d < 2; d++) begin
            req_v[d] = N'($urandom & $urandom);
            a_v[d]   = {$urandom, $urandom, $urandom, $urandom};
            b_v[d]   = {$urandom, $urandom, $urandom, $urandom};
            c_v[d]   = N*C'($urandom);
         end
         zmix = $urandom;
         if ($urandom_range(0, 249) == 0) do_reset();
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
